ysyx_22050133_mdu: RTL and testbench
====================================

# ysyx_22050133_mdu

Iterative multiply/divide unit for the RV64M extension, sequenced by an internal FSM. It replaces the single-cycle `*`, `/` and `%` paths in the execute stage with a shift-add multiplier and a restoring divider that share one accumulator. Operands arrive through a valid/ready handshake, and the result leaves through one. The execute stage stalls while `busy` is high.

## Interface
Parameters
- XLEN, 64, datapath width. Only 64 is supported.

Ports
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  unit can accept a request (state IDLE).
- op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- is_word  in  1  selects the W variant (MULW/DIVW/DIVUW/REMW/REMUW); ignored for op 1–3.
- src1, src2  in  64  operands (rs1, rs2).
- flush  in  1  synchronous kill of the in-flight operation.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- result  out  64  final value.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE → CALC on in_valid && in_ready && !flush, with these prep actions:
  - Latch op and is_word.
  - Latch the absolute values of the signed operands.
  - Record the result sign:
    - MUL*: sign = s1 ^ s2.
    - DIV: sign = s1 ^ s2.
    - REM: sign = s1 only.
  - Load N = 32 if is_word, else 64.
- Signedness:
  - Signed operands: MULH both, MULHSU src1 only, DIV/REM both.
  - MUL/MULW need no sign handling, because the low bits do not depend on it.
  - W variants use src[31:0], sign-extended or zero-extended per op.
- Special cases (IDLE → DONE directly, no CALC or FIX):
  - Divide by zero: quotient = all ones; remainder = dividend.
  - Signed overflow (DIV/REM only, dividend = most-negative, divisor = −1): quotient = dividend, remainder = 0.
  - W forms of both cases use the 32-bit values, sign-extended.
- CALC runs exactly N iterations, one per cycle; a down-counter reaching 0 moves the FSM to FIX.
  - Multiply: 2N-bit accumulator. Each cycle adds the multiplicand when the LSB of the multiplier is 1, then shifts right.
  - Divide: restoring. Shift {rem, quot} left, trial-subtract the divisor, keep the difference when it is non-negative, set the quotient bit.
- FIX (1 cycle):
  - Conditionally negate by the recorded sign.
  - Select the output field: MUL → low XLEN, MULH* → high XLEN, DIV* → quotient, REM* → remainder.
  - W results: SEXT of bits [31:0].
  - Register the result, then go to DONE.
- DONE: out_valid = 1; result is held stable. Leave for IDLE on out_ready. A new request is never accepted in the same cycle as out_ready.
- flush: in any state, the next state is IDLE and out_valid falls next cycle. Flush takes priority over in_valid and out_ready arriving in the same cycle.

## Timing
- Reset values:
  - state = IDLE; out_valid = 0; result = 0; busy = 0.
  - in_ready = 1, as soon as rst deasserts.
  - Counter and accumulators are cleared.
- in_ready is combinational (state == IDLE) and does not depend on in_valid.
- Accept edge at the end of cycle T; out_valid first rises at:
  - 64-bit ops: T+66.
  - W ops: T+34.
  - Special cases: T+1.
- Back-to-back throughput: one op per N+3 cycles at best. The extra cycle is the DONE→IDLE transition.
- If out_ready is held low, result and out_valid remain unchanged indefinitely.
- rst asserted in the middle of an operation returns every output to its reset value immediately, with no clock edge needed.

## Structure
- Add `ysyx_22050133_MDUop_*` funct3 constants and the state encodings to npcdefine.v.
- The EXU decodes M-ops to this unit and muxes `result`.
- One sub-module, `ysyx_22050133_mdu_absneg`: combinational conditional two's-complement negate (width parameter). It is instantiated in prep for the operands and in FIX for the result.
- One 65-bit adder/subtractor is shared between the multiply and divide iterations.

## Test plan
1. MUL src1=7, src2=0xFFFF_FFFF_FFFF_FFFD (−3) → result 0xFFFF_FFFF_FFFF_FFEB, out_valid first at T+66, busy high T+1..T+66.
2. MULHU all-ones × all-ones → 0xFFFF_FFFF_FFFF_FFFE; MULH with the same operands → 0; MULHSU src1=−1, src2=2 → 0xFFFF_FFFF_FFFF_FFFF.
3. DIV −7 / 2 → 0xFFFF_FFFF_FFFF_FFFD; REM −7 % 2 → 0xFFFF_FFFF_FFFF_FFFF; DIVU 100 / 7 → 14; REMU → 2.
4. Special cases, each with out_valid at T+1:
   - DIVU 5/0 → all ones.
   - REMU 5/0 → 5.
   - DIV 0x8000_0000_0000_0000 / −1 → 0x8000_0000_0000_0000.
   - REM of the same operands → 0.
5. W ops, each with out_valid at T+34:
   - DIVW src1=0x0000_0000_FFFF_FFF9, src2=2 → 0xFFFF_FFFF_FFFF_FFFD.
   - MULW 0x7FFF_FFFF × 2 → 0xFFFF_FFFF_FFFF_FFFE.
6. Control sequences:
   - flush on the 10th CALC cycle → IDLE next cycle, no out_valid.
   - out_ready held low 5 cycles in DONE → result stable throughout.
   - rst pulsed low mid-CALC → all outputs return to reset values immediately; the next op completes correctly.

Source files
------------

// File: rtl/ysyx_22050133_mdu_pkg.sv
// ysyx_22050133_mdu_pkg: FSM states, funct3 encodings and helpers for the iterative MDU
package ysyx_22050133_mdu_pkg;
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;
    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction
endpackage

// File: rtl/ysyx_22050133_mdu_absneg.sv
// ysyx_22050133_mdu_absneg: conditional two's-complement negate
module ysyx_22050133_mdu_absneg #(parameter int W = 64) (
    input  logic         neg,
    input  logic [W-1:0] a,
    output logic [W-1:0] y
);
    assign y = neg ? ~a + W'(1) : a;
endmodule

// File: rtl/ysyx_22050133_mdu.sv
// ysyx_22050133_mdu: iterative RV64M multiply/divide unit (shift-add multiply, restoring divide)
module ysyx_22050133_mdu
    import ysyx_22050133_mdu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic            is_word,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    state_t state, state_n;
    logic [2:0] op_r;
    logic w_r, sign_r;
    logic [6:0] cnt;
    logic [XLEN-1:0] opb;
    logic [2*XLEN-1:0] acc, acc_step, fix_in, fix_out;
    logic is_w, s1s, s2s, n1, n2, div_zero, ovf, special, accept, is_div, cout;
    logic [XLEN-1:0] x1, x2, a1, a2, mn, sp_raw, sp_val, fix_sel, fix_val;
    logic [XLEN:0] add_a, add_b, sum;

    assign in_ready  = state == IDLE;
    assign busy      = !in_ready;
    assign out_valid = state == DONE;
    assign accept    = in_valid && in_ready && !flush;

    // W forms only exist for MUL and the divide group
    assign is_w = is_word && (op == OP_MUL || op[2]);
    assign s1s  = op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM;
    assign s2s  = op == OP_MULH || op == OP_DIV || op == OP_REM;
    assign x1   = is_w ? (s1s ? sext32(src1[31:0]) : {32'b0, src1[31:0]}) : src1;
    assign x2   = is_w ? (s2s ? sext32(src2[31:0]) : {32'b0, src2[31:0]}) : src2;
    assign n1   = s1s && x1[XLEN-1];
    assign n2   = s2s && x2[XLEN-1];

    ysyx_22050133_mdu_absneg #(.W(XLEN)) u_abs1 (.neg(n1), .a(x1), .y(a1));
    ysyx_22050133_mdu_absneg #(.W(XLEN)) u_abs2 (.neg(n2), .a(x2), .y(a2));

    assign mn       = is_w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    assign div_zero = op[2] && x2 == '0;
    assign ovf      = (op == OP_DIV || op == OP_REM) && x1 == mn && &x2;
    assign special  = div_zero || ovf;
    assign sp_raw   = op[1] ? (div_zero ? x1 : '0) : (div_zero ? '1 : x1);
    assign sp_val   = is_w ? sext32(sp_raw[31:0]) : sp_raw;

    // Shared 65-bit adder: multiplicand add for MUL, trial subtract for DIV
    assign is_div = op_r[2];
    assign add_a  = is_div ? acc[2*XLEN-1:XLEN-1] : {1'b0, acc[2*XLEN-1:XLEN]};
    assign add_b  = is_div ? ~{1'b0, opb} : (acc[0] ? {1'b0, opb} : '0);
    assign {cout, sum} = {1'b0, add_a} + {1'b0, add_b} + {{(XLEN+1){1'b0}}, is_div};
    assign acc_step = is_div ? {(cout ? sum[XLEN-1:0] : acc[2*XLEN-2:XLEN-1]), acc[XLEN-2:0], cout}
                             : {sum, acc[XLEN-1:1]};

    // A 32-iteration multiply leaves its 64-bit product at acc[95:32]
    assign fix_in  = is_div ? {{XLEN{1'b0}}, (op_r[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0])}
                            : (w_r ? {{XLEN{1'b0}}, acc[95:32]} : acc);
    ysyx_22050133_mdu_absneg #(.W(2*XLEN)) u_fix (.neg(sign_r), .a(fix_in), .y(fix_out));
    assign fix_sel = (!is_div && op_r[1:0] != 2'd0) ? fix_out[2*XLEN-1:XLEN] : fix_out[XLEN-1:0];
    assign fix_val = w_r ? sext32(fix_sel[31:0]) : fix_sel;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: state_n = accept ? (special ? DONE : CALC) : IDLE;
            CALC: state_n = cnt == 7'd1 ? FIX : CALC;
            FIX:  state_n = DONE;
            DONE: state_n = out_ready ? IDLE : DONE;
        endcase
        if (flush) state_n = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_r   <= '0;
            w_r    <= 1'b0;
            sign_r <= 1'b0;
            cnt    <= '0;
            opb    <= '0;
            acc    <= '0;
            result <= '0;
        end else begin
            if (accept) begin
                op_r   <= op;
                w_r    <= is_w;
                sign_r <= (op[2] && op[1]) ? n1 : n1 ^ n2;
                opb    <= op[2] ? a2 : a1;
                acc    <= {{XLEN{1'b0}}, (op[2] ? (is_w ? {a1[31:0], 32'b0} : a1) : a2)};
                cnt    <= is_w ? 7'd32 : 7'd64;
                if (special) result <= sp_val;
            end
            if (state == CALC) begin
                acc <= acc_step;
                cnt <= cnt - 7'd1;
            end
            if (state == FIX) result <= fix_val;
        end
    end
endmodule

// File: tb/tb_ysyx_22050133_mdu.sv
// tb_ysyx_22050133_mdu: directed vectors for the iterative multiply/divide unit
module tb_ysyx_22050133_mdu;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [2:0]  op = 3'd0;
    logic        is_word = 1'b0;
    logic [63:0] src1 = '0, src2 = '0;
    logic        flush = 1'b0;
    logic        out_valid, out_ready = 1'b0, busy;
    logic [63:0] result;
    int n_cmp = 0, n_bad = 0;

    ysyx_22050133_mdu dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .is_word(is_word), .src1(src1), .src2(src2), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic launch(input logic [2:0] o, input logic w, input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        op = o; is_word = w; src1 = a; src2 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic do_op(input string tag, input logic [2:0] o, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp, input int exp_lat, input int hold);
        int lat, busy_lo;
        launch(o, w, a, b);
        lat = 1;
        busy_lo = 0;
        while (!out_valid && lat < 200) begin
            if (!busy) busy_lo++;
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, " busy_low"}, 64'(busy_lo), 64'd0);
        chk(tag, result, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, " hold_result"}, result, exp);
            chk({tag, " hold_valid"}, 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, " back_idle"}, 64'({in_ready, busy, out_valid}), 64'b100);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs", 64'({in_ready, busy, out_valid}), 64'b100);
        chk("reset result", result, 64'd0);
        @(negedge clk) rst = 1'b1;
        #1 chk("in_ready after reset", 64'(in_ready), 64'd1);

        do_op("MUL", 3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 66, 5);
        do_op("MULHU", 3'd3, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 66, 0);
        do_op("MULH", 3'd1, 1'b0, '1, '1, 64'd0, 66, 0);
        do_op("MULHSU", 3'd2, 1'b0, '1, 64'd2, '1, 66, 0);
        do_op("DIV", 3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66, 0);
        do_op("REM", 3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, '1, 66, 0);
        do_op("DIVU", 3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 66, 0);
        do_op("REMU", 3'd7, 1'b0, 64'd100, 64'd7, 64'd2, 66, 0);
        do_op("DIVU by0", 3'd5, 1'b0, 64'd5, 64'd0, '1, 1, 0);
        do_op("REMU by0", 3'd7, 1'b0, 64'd5, 64'd0, 64'd5, 1, 0);
        do_op("DIV ovf", 3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1, 0);
        do_op("REM ovf", 3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1, 0);
        do_op("DIVW", 3'd4, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 34, 0);
        do_op("MULW", 3'd0, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 34, 0);
        do_op("REMUW by0", 3'd7, 1'b1, 64'h1_8000_0000, 64'h1_0000_0000, 64'hFFFF_FFFF_8000_0000, 1, 0);
        do_op("DIVW ovf", 3'd4, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, 0);

        // flush raised on the 10th CALC cycle
        launch(3'd5, 1'b0, 64'd1000, 64'd3);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush to idle", 64'({in_ready, busy, out_valid}), 64'b100);
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("flush no valid", 64'(seen), 64'd0);

        // asynchronous reset mid-CALC
        launch(3'd4, 1'b0, 64'd12345, 64'd11);
        repeat (20) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("async rst outputs", 64'({in_ready, busy, out_valid}), 64'b100);
        chk("async rst result", result, 64'd0);
        @(negedge clk) rst = 1'b1;
        do_op("DIV after rst", 3'd4, 1'b0, 64'd12345, 64'd11, 64'd1122, 66, 0);
        do_op("REM after rst", 3'd6, 1'b0, 64'd12345, 64'd11, 64'd3, 66, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
